// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the F/D/E/M/W hazard controller.
package pipe_ctrl_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MEMWAIT = 2'b01,
    BRFLUSH = 2'b10
  } state_t;

  // Execute-stage operand source selects.
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Default register-address width (matches the WA3 field).
  localparam int RA_W_DEF = 4;

  // Width of the branch flush down-counter; FLUSH_CYC is at most 7.
  localparam int FCNT_W = 3;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline-side hazard inputs and controller outputs.
// master = pipeline/datapath side, slave = hazard controller.
interface pipeline_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int RA_W  = RA_W_DEF,
  parameter int CNT_W = 16
);

  logic [RA_W-1:0]  RA1D, RA2D;
  logic             UsesRA1D, UsesRA2D;
  logic [RA_W-1:0]  RA1E, RA2E;
  logic [RA_W-1:0]  WA3E, WA3M, WA3W;
  logic             RegWriteE, RegWriteM, RegWriteW;
  logic             MemtoRegE;
  logic             PCSrcE;
  logic             MemReqM, MemAckM;

  logic [1:0]       ForwardAE, ForwardBE;
  logic             loadF, loadD, loadE, loadM, loadW;
  logic             flushD, flushE;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output RA1D, RA2D, UsesRA1D, UsesRA2D, RA1E, RA2E,
           WA3E, WA3M, WA3W, RegWriteE, RegWriteM, RegWriteW,
           MemtoRegE, PCSrcE, MemReqM, MemAckM,
    input  ForwardAE, ForwardBE, loadF, loadD, loadE, loadM, loadW,
           flushD, flushE, stall_count
  );

  modport slave (
    input  RA1D, RA2D, UsesRA1D, UsesRA2D, RA1E, RA2E,
           WA3E, WA3M, WA3W, RegWriteE, RegWriteM, RegWriteW,
           MemtoRegE, PCSrcE, MemReqM, MemAckM,
    output ForwardAE, ForwardBE, loadF, loadD, loadE, loadM, loadW,
           flushD, flushE, stall_count
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// Operand forwarding compare for one execute-stage source register.
// The M-stage ALU result is newer than the W result, so it wins.
module forward_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int RA_W = RA_W_DEF
) (
  input  logic [RA_W-1:0] ra_e,
  input  logic [RA_W-1:0] wa_m,
  input  logic [RA_W-1:0] wa_w,
  input  logic            reg_write_m,
  input  logic            reg_write_w,
  output logic [1:0]      fwd
);

  // Priority select: M result, then W result, else register file.
  always_comb begin
    fwd = FWD_RF;
    if (reg_write_m && (wa_m == ra_e)) begin
      fwd = FWD_M;
    end else if (reg_write_w && (wa_w == ra_e)) begin
      fwd = FWD_W;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the F/D/E/M/W filter pipeline.
// Owns every stage load/flush plus the execute-stage forwarding selects.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RA_W      = RA_W_DEF,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_CYC - 1);

  // Reset release synchroniser; run_ok rises on the second edge after release.
  logic [1:0] rst_sync_reg;
  logic       run_ok;

  // Two-flop deassert chain: assert asynchronously, release synchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_reg <= 2'b00;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end

  assign run_ok = rst_sync_reg[1];

  // Forwarding: one compare unit per execute operand (A, B).
  logic [1:0][RA_W-1:0] ra_e;
  logic [1:0][1:0]      fwd_raw;

  assign ra_e[0] = hz.RA1E;
  assign ra_e[1] = hz.RA2E;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    forward_unit #(
      .RA_W (RA_W)
    ) u_fwd (
      .ra_e        (ra_e[gi]),
      .wa_m        (hz.WA3M),
      .wa_w        (hz.WA3W),
      .reg_write_m (hz.RegWriteM),
      .reg_write_w (hz.RegWriteW),
      .fwd         (fwd_raw[gi])
    );
  end

  assign hz.ForwardAE = run_ok ? fwd_raw[0] : FWD_RF;
  assign hz.ForwardBE = run_ok ? fwd_raw[1] : FWD_RF;

  // Hazard conditions seen this cycle.
  logic load_use;
  logic mem_block;

  assign load_use = hz.MemtoRegE & hz.RegWriteE &
                    ((hz.UsesRA1D & (hz.RA1D == hz.WA3E)) |
                     (hz.UsesRA2D & (hz.RA2D == hz.WA3E)));
  assign mem_block = hz.MemReqM & ~hz.MemAckM;

  // Sequencing state. A non-zero count while in MEMWAIT means the freeze
  // interrupted a branch flush that must resume once the ack arrives.
  state_t              state_reg, state_next;
  logic [FCNT_W-1:0]   cnt_reg, cnt_next;
  logic                load_f, load_d, load_e, load_m, load_w;
  logic                flush_d, flush_e;
  logic                do_run, do_br;

  // Next-state and stage-control decode; memory wait > branch > load-use.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load_f     = 1'b0;
    load_d     = 1'b0;
    load_e     = 1'b0;
    load_m     = 1'b0;
    load_w     = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    do_run     = 1'b0;
    do_br      = 1'b0;

    unique case (state_reg)
      RUN: begin
        if (mem_block) state_next = MEMWAIT;
        else           do_run     = 1'b1;
      end
      MEMWAIT: begin
        // Frozen until the ack; the ack cycle itself proceeds normally.
        if (hz.MemAckM) begin
          if (cnt_reg != '0) do_br  = 1'b1;
          else               do_run = 1'b1;
        end
      end
      BRFLUSH: begin
        if (mem_block) state_next = MEMWAIT;
        else           do_br      = 1'b1;
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase

    if (do_run) begin
      state_next = RUN;
      cnt_next   = '0;
      load_f     = 1'b1;
      load_d     = 1'b1;
      load_e     = 1'b1;
      load_m     = 1'b1;
      load_w     = 1'b1;
      if (hz.PCSrcE) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
        if (FLUSH_CYC > 1) begin
          state_next = BRFLUSH;
          cnt_next   = FLUSH_RELOAD;
        end
      end else if (load_use) begin
        // Hold F and D one cycle and send a bubble into E.
        load_f  = 1'b0;
        load_d  = 1'b0;
        flush_e = 1'b1;
      end
    end

    if (do_br) begin
      load_f  = 1'b1;
      load_d  = 1'b1;
      load_e  = 1'b1;
      load_m  = 1'b1;
      load_w  = 1'b1;
      flush_d = 1'b1;
      if (hz.PCSrcE) begin
        flush_e    = 1'b1;
        state_next = BRFLUSH;
        cnt_next   = FLUSH_RELOAD;
      end else if (cnt_reg <= FCNT_W'(1)) begin
        state_next = RUN;
        cnt_next   = '0;
      end else begin
        state_next = BRFLUSH;
        cnt_next   = cnt_reg - FCNT_W'(1);
      end
    end
  end

  // State and flush counter; held at RUN until the synchroniser releases.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else if (!run_ok) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign hz.loadF  = run_ok & load_f;
  assign hz.loadD  = run_ok & load_d;
  assign hz.loadE  = run_ok & load_e;
  assign hz.loadM  = run_ok & load_m;
  assign hz.loadW  = run_ok & load_w;
  assign hz.flushD = ~run_ok | flush_d;
  assign hz.flushE = ~run_ok | flush_e;

  // Saturating count of fetch-stall cycles, not counted while in reset.
  logic [CNT_W-1:0] stall_count_reg;

  // Count stalled cycles; stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_reg <= '0;
    end else if (run_ok && !load_f && (stall_count_reg != {CNT_W{1'b1}})) begin
      stall_count_reg <= stall_count_reg + 1'b1;
    end
  end

  assign hz.stall_count = stall_count_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: each step drives one cycle of
// inputs, queues the expected controls and stall count, then checks them.
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic reset;

  pipeline_hazard_ctrl_if #(.RA_W(4), .CNT_W(3)) hz ();

  pipeline_hazard_ctrl #(
    .RA_W      (4),
    .FLUSH_CYC (3),
    .CNT_W     (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control vector: {FA[1:0], FB[1:0], lF, lD, lE, lM, lW, fD, fE}
  localparam logic [10:0] C_RST = {2'b00, 2'b00, 5'b00000, 2'b11};
  localparam logic [10:0] C_RUN = {2'b00, 2'b00, 5'b11111, 2'b00};
  localparam logic [10:0] C_FRZ = {2'b00, 2'b00, 5'b00000, 2'b00};
  localparam logic [10:0] C_BR  = {2'b00, 2'b00, 5'b11111, 2'b11};
  localparam logic [10:0] C_BRF = {2'b00, 2'b00, 5'b11111, 2'b10};
  localparam logic [10:0] C_LU  = {2'b00, 2'b00, 5'b00111, 2'b01};

  typedef struct {
    string       tag;
    logic [10:0] ctl;
    logic [2:0]  cnt;
  } sb_t;

  sb_t        sb[$];
  int         checks;
  int         errors;
  logic [2:0] exp_stall;
  bit         exp_active;

  function automatic logic [10:0] fwd_ctl(input logic [1:0] fa, input logic [1:0] fb);
    return {fa, fb, 5'b11111, 2'b00};
  endfunction

  task automatic clr_inputs();
    hz.RA1D = '0; hz.RA2D = '0; hz.UsesRA1D = 1'b0; hz.UsesRA2D = 1'b0;
    hz.RA1E = '0; hz.RA2E = '0;
    hz.WA3E = '0; hz.WA3M = '0; hz.WA3W = '0;
    hz.RegWriteE = 1'b0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
    hz.MemtoRegE = 1'b0; hz.PCSrcE = 1'b0;
    hz.MemReqM = 1'b0; hz.MemAckM = 1'b0;
  endtask

  // Queue the expectation for the cycle just driven, check it at the
  // falling edge, then advance to just after the next rising edge.
  task automatic step(input string tag, input logic [10:0] ctl);
    sb_t         e;
    sb_t         got;
    logic [10:0] obs;
    e.tag = tag;
    e.ctl = ctl;
    e.cnt = exp_stall;
    sb.push_back(e);
    if (exp_active && !ctl[6] && (exp_stall != 3'b111)) exp_stall = exp_stall + 3'd1;
    @(negedge clk);
    got = sb.pop_front();
    obs = {hz.ForwardAE, hz.ForwardBE, hz.loadF, hz.loadD, hz.loadE,
           hz.loadM, hz.loadW, hz.flushD, hz.flushE};
    checks++;
    assert (obs === got.ctl) else begin
      errors++;
      $error("FAIL %s ctl observed=%b expected=%b", got.tag, obs, got.ctl);
    end
    checks++;
    assert (hz.stall_count === got.cnt) else begin
      errors++;
      $error("FAIL %s stall_count observed=%0d expected=%0d", got.tag, hz.stall_count, got.cnt);
    end
    $display("step %-10s ctl=%b stall=%0d", got.tag, obs, hz.stall_count);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks     = 0;
    errors     = 0;
    exp_stall  = '0;
    exp_active = 1'b0;
    reset      = 1'b0;
    clr_inputs();

    // Reset holds everything off, forwarding included.
    hz.RA1E = 4'd3; hz.WA3M = 4'd3; hz.RegWriteM = 1'b1;
    step("rst_hold0", C_RST);
    step("rst_hold1", C_RST);

    // Release: still in reset for two edges.
    reset = 1'b1;
    step("rel1", C_RST);
    step("rel2", C_RST);
    exp_active = 1'b1;

    // Forwarding priority.
    hz.WA3W = 4'd3; hz.RegWriteW = 1'b1;
    step("fwd_m", fwd_ctl(2'b10, 2'b00));
    hz.RegWriteM = 1'b0;
    step("fwd_w", fwd_ctl(2'b01, 2'b00));
    hz.RegWriteW = 1'b0;
    step("fwd_rf", fwd_ctl(2'b00, 2'b00));
    hz.RegWriteM = 1'b1; hz.RegWriteW = 1'b1; hz.RA2E = 4'd7; hz.WA3W = 4'd7;
    step("fwd_b_w", fwd_ctl(2'b10, 2'b01));
    hz.WA3M = 4'd7;
    step("fwd_b_m", fwd_ctl(2'b00, 2'b10));
    clr_inputs();

    // Load-use on operand B, then the bubble leaves E.
    hz.MemtoRegE = 1'b1; hz.RegWriteE = 1'b1; hz.WA3E = 4'd5;
    hz.RA2D = 4'd5; hz.UsesRA2D = 1'b1;
    step("lu_b", C_LU);
    hz.MemtoRegE = 1'b0; hz.RegWriteE = 1'b0;
    step("lu_after", C_RUN);
    hz.MemtoRegE = 1'b1; hz.RegWriteE = 1'b1; hz.UsesRA2D = 1'b0;
    step("lu_nouse", C_RUN);
    hz.RA1D = 4'd5; hz.UsesRA1D = 1'b1;
    step("lu_a", C_LU);
    clr_inputs();

    // Multi-cycle memory access.
    hz.MemReqM = 1'b1;
    step("mem0", C_FRZ);
    step("mem1", C_FRZ);
    step("mem2", C_FRZ);
    step("mem3", C_FRZ);
    hz.MemAckM = 1'b1;
    step("mem_ack", C_RUN);
    clr_inputs();
    step("mem_done", C_RUN);

    // Taken branch, three-cycle flushD.
    hz.PCSrcE = 1'b1;
    step("br0", C_BR);
    hz.PCSrcE = 1'b0;
    step("br1", C_BRF);
    step("br2", C_BRF);
    step("br3", C_RUN);

    // Branch arriving during a memory freeze waits for the ack.
    hz.PCSrcE = 1'b1; hz.MemReqM = 1'b1;
    step("frz0", C_FRZ);
    step("frz1", C_FRZ);
    hz.MemAckM = 1'b1;
    step("frz_ack", C_BR);
    clr_inputs();
    step("frz_br1", C_BRF);
    step("frz_br2", C_BRF);
    step("frz_end", C_RUN);

    // Memory freeze in the middle of a branch flush resumes the flush.
    hz.PCSrcE = 1'b1;
    step("bf0", C_BR);
    hz.PCSrcE = 1'b0; hz.MemReqM = 1'b1;
    step("bf_mem", C_FRZ);
    hz.MemAckM = 1'b1;
    step("bf_ack", C_BRF);
    clr_inputs();
    step("bf1", C_BRF);
    step("bf_end", C_RUN);

    // Re-branch during a flush reloads the counter.
    hz.PCSrcE = 1'b1;
    step("rb0", C_BR);
    step("rb1", C_BR);
    hz.PCSrcE = 1'b0;
    step("rb2", C_BRF);
    step("rb3", C_BRF);
    step("rb4", C_RUN);

    // Reset in the middle of a memory wait.
    hz.MemReqM = 1'b1;
    step("rm0", C_FRZ);
    step("rm1", C_FRZ);
    reset      = 1'b0;
    exp_active = 1'b0;
    exp_stall  = '0;
    step("rm_rst", C_RST);
    clr_inputs();
    reset = 1'b1;
    step("rr1", C_RST);
    step("rr2", C_RST);
    exp_active = 1'b1;
    step("rr_run", C_RUN);
    hz.MemtoRegE = 1'b1; hz.RegWriteE = 1'b1; hz.WA3E = 4'd9;
    hz.RA1D = 4'd9; hz.UsesRA1D = 1'b1;
    step("rr_lu", C_LU);
    clr_inputs();
    step("rr_cnt", C_RUN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
